// File: rtl/mipi_rx_packet_decoder.sv
// CSI-2 packet decoder: splits the lane-aligned 4-byte stream into header
// fields, short-packet event pulses and 32-bit payload beats with byte enables.
// Trailer/CRC bytes are masked or discarded and truncated packets are flagged.
module mipi_rx_packet_decoder #(
    parameter int unsigned LANES  = 4,
    parameter int unsigned MAX_WC = 32'h0000_FFFF
) (
    input  logic                 clk_i,
    input  logic                 reset_n_i,
    input  logic                 lane_valid_i,
    input  logic [8*LANES-1:0]   lane_byte_i,
    output logic [8*LANES-1:0]   payload_o,
    output logic                 payload_valid_o,
    output logic [LANES-1:0]     payload_be_o,
    output logic                 payload_last_o,
    output logic [5:0]           data_type_o,
    output logic [1:0]           virtual_channel_o,
    output logic [15:0]          word_count_o,
    output logic                 frame_start_o,
    output logic                 frame_end_o,
    output logic                 line_start_o,
    output logic                 line_end_o,
    output logic                 packet_error_o
);

    localparam int unsigned DW  = 8 * LANES;
    localparam int unsigned SHW = $clog2(LANES + 1);
    localparam logic [LANES-1:0] BE_ALL = '1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PAYLOAD = 2'd1,
        ST_DRAIN   = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] rem_q, rem_d;
    logic        valid_q;

    logic [7:0]  hdr_di;
    logic [15:0] hdr_wc;
    logic        hdr_start;
    logic        is_short;
    logic        wc_over;
    logic        last_beat;

    logic [DW-1:0]    payload_d;
    logic             pvalid_d;
    logic [LANES-1:0] be_d;
    logic             last_d;
    logic [5:0]       dt_d;
    logic [1:0]       vc_d;
    logic [15:0]      wc_d;
    logic             fs_d, fe_d, ls_d, le_d, err_d;

    // Header field extraction; a header is only accepted on a rising edge of lane_valid_i
    assign hdr_di    = lane_byte_i[7:0];
    assign hdr_wc    = {lane_byte_i[23:16], lane_byte_i[15:8]};
    assign hdr_start = lane_valid_i && !valid_q;
    assign is_short  = (hdr_di[5:0] < 6'h10);
    assign wc_over   = (32'(hdr_wc) > MAX_WC);
    assign last_beat = (rem_q <= 16'(LANES));

    // State register; valid_q resets high so a stream already in flight at reset release is ignored
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q <= ST_IDLE;
            rem_q   <= '0;
            valid_q <= 1'b1;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            valid_q <= lane_valid_i;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (hdr_start) begin
                    if (is_short || (hdr_wc == 16'd0) || wc_over) state_d = ST_DRAIN;
                    else                                         state_d = ST_PAYLOAD;
                end
            end
            ST_PAYLOAD: begin
                if (!lane_valid_i)  state_d = ST_IDLE;
                else if (last_beat) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (!lane_valid_i) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Output and counter next values; pulses default low, header fields hold
    always_comb begin
        rem_d     = rem_q;
        payload_d = payload_o;
        pvalid_d  = 1'b0;
        be_d      = '0;
        last_d    = 1'b0;
        dt_d      = data_type_o;
        vc_d      = virtual_channel_o;
        wc_d      = word_count_o;
        fs_d      = 1'b0;
        fe_d      = 1'b0;
        ls_d      = 1'b0;
        le_d      = 1'b0;
        err_d     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (hdr_start) begin
                    dt_d = hdr_di[5:0];
                    vc_d = hdr_di[7:6];
                    if (is_short) begin
                        fs_d = (hdr_di[5:0] == 6'h00);
                        fe_d = (hdr_di[5:0] == 6'h01);
                        ls_d = (hdr_di[5:0] == 6'h02);
                        le_d = (hdr_di[5:0] == 6'h03);
                    end else if (wc_over) begin
                        err_d = 1'b1;
                    end else begin
                        wc_d  = hdr_wc;
                        rem_d = hdr_wc;
                    end
                end
            end
            ST_PAYLOAD: begin
                if (!lane_valid_i) begin
                    err_d = 1'b1;
                end else begin
                    pvalid_d  = 1'b1;
                    payload_d = lane_byte_i;
                    if (last_beat) begin
                        be_d   = ~(BE_ALL << rem_q[SHW-1:0]);
                        last_d = 1'b1;
                    end else begin
                        be_d  = BE_ALL;
                        rem_d = rem_q - 16'(LANES);
                    end
                end
            end
            default: ;
        endcase
    end

    // Output registers
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            payload_o         <= '0;
            payload_valid_o   <= 1'b0;
            payload_be_o      <= '0;
            payload_last_o    <= 1'b0;
            data_type_o       <= '0;
            virtual_channel_o <= '0;
            word_count_o      <= '0;
            frame_start_o     <= 1'b0;
            frame_end_o       <= 1'b0;
            line_start_o      <= 1'b0;
            line_end_o        <= 1'b0;
            packet_error_o    <= 1'b0;
        end else begin
            payload_o         <= payload_d;
            payload_valid_o   <= pvalid_d;
            payload_be_o      <= be_d;
            payload_last_o    <= last_d;
            data_type_o       <= dt_d;
            virtual_channel_o <= vc_d;
            word_count_o      <= wc_d;
            frame_start_o     <= fs_d;
            frame_end_o       <= fe_d;
            line_start_o      <= ls_d;
            line_end_o        <= le_d;
            packet_error_o    <= err_d;
        end
    end

endmodule

// File: tb/tb_mipi_rx_packet_decoder.sv
// Scoreboard bench for mipi_rx_packet_decoder: stimulus pushes expected beats
// and event pulses (with the cycle they must appear in); a negedge monitor pops them.
module tb_mipi_rx_packet_decoder;

    logic        clk_i = 1'b0;
    logic        reset_n_i;
    logic        lane_valid_i;
    logic [31:0] lane_byte_i;
    logic [31:0] payload_o;
    logic        payload_valid_o;
    logic [3:0]  payload_be_o;
    logic        payload_last_o;
    logic [5:0]  data_type_o;
    logic [1:0]  virtual_channel_o;
    logic [15:0] word_count_o;
    logic        frame_start_o, frame_end_o, line_start_o, line_end_o, packet_error_o;

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  be;
        logic        last;
        logic [31:0] stamp;
    } beat_t;

    typedef struct packed {
        logic [4:0]  code;   // {err, line_end, line_start, frame_end, frame_start}
        logic [31:0] stamp;
    } evt_t;

    localparam logic [4:0] E_FS = 5'b00001, E_FE = 5'b00010, E_LS = 5'b00100,
                           E_LE = 5'b01000, E_ERR = 5'b10000;

    beat_t beat_q[$];
    evt_t  evt_q[$];
    int    checks = 0;
    int    errors = 0;
    int    cyc = 0;

    mipi_rx_packet_decoder dut (
        .clk_i             (clk_i),
        .reset_n_i         (reset_n_i),
        .lane_valid_i      (lane_valid_i),
        .lane_byte_i       (lane_byte_i),
        .payload_o         (payload_o),
        .payload_valid_o   (payload_valid_o),
        .payload_be_o      (payload_be_o),
        .payload_last_o    (payload_last_o),
        .data_type_o       (data_type_o),
        .virtual_channel_o (virtual_channel_o),
        .word_count_o      (word_count_o),
        .frame_start_o     (frame_start_o),
        .frame_end_o       (frame_end_o),
        .line_start_o      (line_start_o),
        .line_end_o        (line_end_o),
        .packet_error_o    (packet_error_o)
    );

    always #5 clk_i = ~clk_i;

    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic drive(input logic v, input logic [31:0] d);
        @(negedge clk_i);
        lane_valid_i = v;
        lane_byte_i  = d;
    endtask

    task automatic exp_beat(input logic [31:0] d, input logic [3:0] be, input logic l);
        beat_t b;
        b.data = d; b.be = be; b.last = l; b.stamp = 32'(cyc + 1);
        beat_q.push_back(b);
    endtask

    task automatic exp_evt(input logic [4:0] code);
        evt_t e;
        e.code = code; e.stamp = 32'(cyc + 1);
        evt_q.push_back(e);
    endtask

    task automatic chk_all_zero(input string name);
        chk({name, "_payload"}, 64'(payload_o), 64'd0);
        chk({name, "_ctrl"}, 64'({payload_valid_o, payload_be_o, payload_last_o, data_type_o,
                                 virtual_channel_o, word_count_o, frame_start_o, frame_end_o,
                                 line_start_o, line_end_o, packet_error_o}), 64'd0);
    endtask

    task automatic chk_hdr(input string name, input logic [5:0] dt, input logic [1:0] vc,
                           input logic [15:0] wc);
        chk({name, "_dt"}, 64'(data_type_o), 64'(dt));
        chk({name, "_vc"}, 64'(virtual_channel_o), 64'(vc));
        chk({name, "_wc"}, 64'(word_count_o), 64'(wc));
    endtask

    // Monitor: every output beat or event pulse must match the oldest expectation
    always @(negedge clk_i) begin
        beat_t      b;
        evt_t       e;
        logic [4:0] code;
        if (payload_valid_o) begin
            if (beat_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL beat_unexpected: got data %0h be %0b, none expected (cycle %0d)",
                         payload_o, payload_be_o, cyc);
            end else begin
                b = beat_q.pop_front();
                chk("beat_data", 64'(payload_o), 64'(b.data));
                chk("beat_be", 64'(payload_be_o), 64'(b.be));
                chk("beat_last", 64'(payload_last_o), 64'(b.last));
                chk("beat_cycle", 64'(cyc), 64'(b.stamp));
            end
        end else if (payload_last_o) begin
            checks++; errors++;
            $display("FAIL last_without_valid: got last=1 required 0 (cycle %0d)", cyc);
        end
        code = {packet_error_o, line_end_o, line_start_o, frame_end_o, frame_start_o};
        if (code != 5'd0) begin
            if (evt_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL evt_unexpected: got %05b, none expected (cycle %0d)", code, cyc);
            end else begin
                e = evt_q.pop_front();
                chk("evt_code", 64'(code), 64'(e.code));
                chk("evt_cycle", 64'(cyc), 64'(e.stamp));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, got no finish required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n_i    = 1'b0;
        lane_valid_i = 1'b0;
        lane_byte_i  = '0;
        repeat (2) @(negedge clk_i);
        chk_all_zero("reset");
        reset_n_i = 1'b1;
        drive(0, 32'h0);
        drive(0, 32'h0);

        // Frame start, VC0
        drive(1, 32'hA500_0000); exp_evt(E_FS);
        drive(0, 32'h0);
        drive(0, 32'h0);
        chk_hdr("fs", 6'h00, 2'd0, 16'd0);

        // Long DI=0x2B WC=8: two full beats, CRC cycle discarded
        drive(1, 32'h3C00_082B);
        drive(1, 32'hDEAD_BEEF); exp_beat(32'hDEAD_BEEF, 4'b1111, 1'b0);
        drive(1, 32'h0123_4567); exp_beat(32'h0123_4567, 4'b1111, 1'b1);
        drive(1, 32'h0000_ABCD);
        drive(0, 32'h0);
        drive(0, 32'h0);
        chk_hdr("wc8", 6'h2B, 2'd0, 16'd8);

        // Long DI=0x6A (VC1, DT 0x2A) WC=6: second beat only 2 bytes enabled
        drive(1, 32'h1100_066A);
        drive(1, 32'h4433_2211); exp_beat(32'h4433_2211, 4'b1111, 1'b0);
        drive(1, 32'hC0DE_5566); exp_beat(32'hC0DE_5566, 4'b0011, 1'b1);
        drive(0, 32'h0);
        drive(0, 32'h0);
        chk_hdr("wc6", 6'h2A, 2'd1, 16'd6);

        // Long WC=40 truncated after 5 payload cycles
        drive(1, 32'h0000_282B);
        for (int i = 0; i < 5; i++) begin
            drive(1, 32'h1000_0000 + 32'(i));
            exp_beat(32'h1000_0000 + 32'(i), 4'b1111, 1'b0);
        end
        drive(0, 32'h0); exp_evt(E_ERR);
        // Next packet one low cycle later: line start VC2
        drive(1, 32'h0000_0082); exp_evt(E_LS);
        drive(0, 32'h0);
        drive(0, 32'h0);
        chk_hdr("abort_next", 6'h02, 2'd2, 16'd40);

        // Long WC=0 (VC3 DT 0x2B), one idle cycle, then line end VC1
        drive(1, 32'h0000_00EB);
        @(negedge clk_i);
        chk_hdr("wc0", 6'h2B, 2'd3, 16'd0);
        lane_valid_i = 1'b0;
        lane_byte_i  = 32'h0;
        drive(1, 32'h0000_0043); exp_evt(E_LE);
        drive(0, 32'h0);
        drive(0, 32'h0);
        chk_hdr("le", 6'h03, 2'd1, 16'd0);

        // Reserved short DT 0x05 gives no pulse; then frame end
        drive(1, 32'h0000_0005);
        drive(0, 32'h0);
        drive(1, 32'h0000_0001); exp_evt(E_FE);
        drive(0, 32'h0);
        drive(0, 32'h0);
        chk_hdr("fe", 6'h01, 2'd0, 16'd0);

        // Async reset in the middle of a WC=16 payload
        drive(1, 32'h0000_102B);
        drive(1, 32'hAAAA_0001); exp_beat(32'hAAAA_0001, 4'b1111, 1'b0);
        drive(1, 32'hAAAA_0002);
        #2 reset_n_i = 1'b0;
        #1 chk_all_zero("async_rst");
        @(negedge clk_i);
        reset_n_i = 1'b1;
        for (int i = 0; i < 3; i++) drive(1, 32'hBBBB_0000 + 32'(i));
        drive(0, 32'h0);
        chk_hdr("post_rst", 6'h00, 2'd0, 16'd0);
        drive(1, 32'h0000_0042); exp_evt(E_LS);
        drive(0, 32'h0);
        drive(0, 32'h0);
        chk_hdr("post_rst_ls", 6'h02, 2'd1, 16'd0);

        repeat (4) @(negedge clk_i);
        chk("beats_left", 64'(beat_q.size()), 64'd0);
        chk("evts_left", 64'(evt_q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
